// File: rtl/acc_calc_pkg.sv
// Shared types and constants for the accuracy calculator.
package acc_calc_pkg;

  typedef enum logic [1:0] {
    ACCUM  = 2'd0,
    DIVIDE = 2'd1,
    DONE   = 2'd2
  } state_t;

  localparam int unsigned PCT_SCALE = 100;

  // Dividend must hold correct_cnt * 100, i.e. 7 extra bits over the counter.
  function automatic int unsigned dividend_w(input int unsigned cnt_w);
    return cnt_w + 7;
  endfunction

endpackage

// File: rtl/acc_calc_seq_divider.sv
// Restoring shift-subtract divider, one quotient bit per cycle, MSB first.
module seq_divider #(
  parameter int unsigned DW = 14
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clear,
  input  logic          start,
  input  logic [DW-1:0] dividend,
  input  logic [DW-1:0] divisor,
  output logic          busy,
  output logic          done,
  output logic [DW-1:0] quotient
);

  localparam int unsigned IW = $clog2(DW + 1);

  logic [DW-1:0] rem_q;
  logic [DW-1:0] div_q;
  logic [IW-1:0] iter_q;
  logic [DW:0]   trial;
  logic          fits;
  logic [DW-1:0] rem_nxt;
  logic [DW-1:0] quo_nxt;

  // Quotient bits shift in at the bottom while dividend bits shift out the top.
  always_comb begin
    trial   = {rem_q, quotient[DW-1]};
    fits    = trial >= {1'b0, div_q};
    rem_nxt = fits ? DW'(trial - {1'b0, div_q}) : trial[DW-1:0];
    quo_nxt = {quotient[DW-2:0], fits};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem_q    <= '0;
      div_q    <= '0;
      iter_q   <= '0;
      quotient <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else if (clear) begin
      rem_q    <= '0;
      div_q    <= '0;
      iter_q   <= '0;
      quotient <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else if (start) begin
      rem_q    <= '0;
      div_q    <= divisor;
      iter_q   <= IW'(DW);
      quotient <= dividend;
      busy     <= 1'b1;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      if (busy) begin
        rem_q    <= rem_nxt;
        quotient <= quo_nxt;
        iter_q   <= iter_q - IW'(1);
        if (iter_q == IW'(1)) begin
          busy <= 1'b0;
          done <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/acc_calc.sv
// Thresholds classifier scores, counts correct predictions and reports percent accuracy.
module acc_calc
  import acc_calc_pkg::*;
#(
  parameter int unsigned NUM_SAMPLES = 100,
  parameter int unsigned SCORE_W     = 32,
  parameter logic signed [SCORE_W-1:0] THRESH = SCORE_W'(32'sh0080_0000),
  localparam int unsigned CNT_W = $clog2(NUM_SAMPLES + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clear,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [SCORE_W-1:0] in_score,
  input  logic               in_label,
  output logic [CNT_W-1:0]   sample_cnt,
  output logic [CNT_W-1:0]   correct_cnt,
  output logic [7:0]         acc_pct,
  output logic               acc_cal
);

  localparam int unsigned DW = dividend_w(CNT_W);

  state_t        state_q, state_d;
  logic [1:0]    rst_sync_q;
  logic          rst_int_n;
  logic          transfer;
  logic          hit;
  logic          last;
  logic [CNT_W-1:0] correct_nxt;
  logic [DW-1:0] dividend;
  logic          div_busy;
  logic          div_done;
  logic [DW-1:0] quotient;

  // Asynchronous assertion, synchronous release of the internal reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_sync_q <= 2'b00;
    else        rst_sync_q <= {rst_sync_q[0], 1'b1};
  end
  assign rst_int_n = rst_sync_q[1];

  assign in_ready    = (state_q == ACCUM);
  assign transfer    = in_valid && in_ready && !clear;
  assign hit         = (($signed(in_score) >= THRESH) == in_label);
  assign last        = transfer && (sample_cnt == CNT_W'(NUM_SAMPLES - 1));
  assign correct_nxt = correct_cnt + CNT_W'(hit);
  assign dividend    = DW'(correct_nxt) * DW'(PCT_SCALE);

  seq_divider #(.DW(DW)) u_div (
    .clk      (clk),
    .rst_n    (rst_int_n),
    .clear    (clear),
    .start    (last),
    .dividend (dividend),
    .divisor  (DW'(NUM_SAMPLES)),
    .busy     (div_busy),
    .done     (div_done),
    .quotient (quotient)
  );

  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) state_q <= ACCUM;
    else            state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (clear) begin
      state_d = ACCUM;
    end else begin
      case (state_q)
        ACCUM:   if (last) state_d = DIVIDE;
        DIVIDE:  if (div_done && !div_busy) state_d = DONE;
        DONE:    state_d = DONE;
        default: state_d = ACCUM;
      endcase
    end
  end

  // Counters and result registers; clear wins over a same-cycle transfer.
  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      sample_cnt  <= '0;
      correct_cnt <= '0;
      acc_pct     <= '0;
      acc_cal     <= 1'b0;
    end else if (clear) begin
      sample_cnt  <= '0;
      correct_cnt <= '0;
      acc_pct     <= '0;
      acc_cal     <= 1'b0;
    end else begin
      if (transfer) begin
        sample_cnt  <= sample_cnt + CNT_W'(1);
        correct_cnt <= correct_nxt;
      end
      if (state_q == DIVIDE && div_done) begin
        acc_pct <= (quotient > DW'(PCT_SCALE)) ? 8'(PCT_SCALE) : quotient[7:0];
        acc_cal <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_acc_calc.sv
// Randomized self-checking bench for acc_calc against a behavioural accuracy model.
module tb_acc_calc;

  localparam int N   = 100;
  localparam int LAT = 15;
  localparam logic signed [31:0] TH = 32'sh0080_0000;

  logic        clk = 1'b0;
  logic        rst_n, clear, in_valid, in_label;
  logic [31:0] in_score;
  logic        in_ready;
  logic [6:0]  sample_cnt, correct_cnt;
  logic [7:0]  acc_pct;
  logic        acc_cal;

  logic        clear3, v3, l3, r3, cal3;
  logic [31:0] s3;
  logic [1:0]  sc3, cc3;
  logic [7:0]  pct3;

  int pass_cnt = 0;
  int total_cnt = 0;

  acc_calc dut (
    .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_ready(in_ready),
    .in_score(in_score), .in_label(in_label), .sample_cnt(sample_cnt),
    .correct_cnt(correct_cnt), .acc_pct(acc_pct), .acc_cal(acc_cal)
  );

  acc_calc #(.NUM_SAMPLES(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .clear(clear3), .in_valid(v3), .in_ready(r3),
    .in_score(s3), .in_label(l3), .sample_cnt(sc3),
    .correct_cnt(cc3), .acc_pct(pct3), .acc_cal(cal3)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    total_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Model: counts accepted rows, then the result appears LAT edges after the final accept.
  int   m_samp, m_corr, m_edges;
  logic m_done;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n || clear) begin
      m_samp  <= 0;
      m_corr  <= 0;
      m_edges <= -1;
      m_done  <= 1'b0;
    end else if (m_edges < 0) begin
      if (in_valid) begin
        m_samp <= m_samp + 1;
        m_corr <= m_corr + int'(($signed(in_score) >= TH) == in_label);
        if (m_samp + 1 == N) m_edges <= 0;
      end
    end else if (!m_done) begin
      m_edges <= m_edges + 1;
      if (m_edges + 1 == LAT) m_done <= 1'b1;
    end
  end

  always @(negedge clk) begin
    chk("sample_cnt", int'(sample_cnt), m_samp);
    chk("correct_cnt", int'(correct_cnt), m_corr);
    chk("in_ready", int'(in_ready), int'(m_edges < 0));
    chk("acc_cal", int'(acc_cal), int'(m_done));
    chk("acc_pct", int'(acc_pct), m_done ? (m_corr * 100) / N : 0);
  end

  task automatic send(input logic [31:0] s, input logic l, input int gap);
    while (int'($urandom_range(99)) < gap) begin
      @(posedge clk); #1;
    end
    in_valid = 1'b1; in_score = s; in_label = l;
    @(posedge clk); #1;
    in_valid = 1'b0; in_score = $urandom; in_label = 1'($urandom);
  endtask

  // kind 0: fixed positive score; 1: alternating +/-; 2: random with exact-threshold rows.
  task automatic run(input int ncorr, input int gap, input int kind, input int rows);
    int remain;
    logic [31:0] s;
    logic pred, want;
    remain = ncorr;
    for (int i = 0; i < rows; i++) begin
      case (kind)
        0:       s = 32'h0100_0000;
        1:       s = (i % 2 == 0) ? 32'h0100_0000 : 32'hFF00_0000;
        default: s = ($urandom_range(7) == 0) ? 32'(TH) : $urandom;
      endcase
      pred = ($signed(s) >= TH);
      if (kind == 2) want = (int'($urandom_range(N - 1 - i)) < remain);
      else           want = (i < ncorr);
      if (want) remain--;
      send(s, kind == 0 ? 1'b1 : (want ? pred : !pred), gap);
    end
  endtask

  task automatic wait_done();
    int k;
    k = 0;
    while (!acc_cal && k < 40) begin
      @(posedge clk); #1;
      k++;
    end
    chk("acc_cal_latency", k, LAT);
  endtask

  task automatic do_clear();
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
  endtask

  initial begin
    int nc;
    rst_n = 1'b0; clear = 1'b0; in_valid = 1'b0; in_score = '0; in_label = 1'b0;
    clear3 = 1'b0; v3 = 1'b0; s3 = '0; l3 = 1'b0;
    #22 rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_sample_cnt", int'(sample_cnt), 0);
    chk("rst_in_ready", int'(in_ready), 1);
    chk("rst_acc_cal", int'(acc_cal), 0);

    run(100, 0, 0, N);
    wait_done();
    chk("all_correct_cnt", int'(correct_cnt), 100);
    chk("all_correct_pct", int'(acc_pct), 100);
    chk("done_in_ready", int'(in_ready), 0);
    in_valid = 1'b1;
    repeat (5) @(posedge clk);
    #1 in_valid = 1'b0;
    chk("done_hold_samples", int'(sample_cnt), 100);

    do_clear();
    run(67, 0, 1, N);
    wait_done();
    chk("alt67_pct", int'(acc_pct), 67);
    chk("alt67_cnt", int'(correct_cnt), 67);

    do_clear();
    run(0, 0, 1, N);
    wait_done();
    chk("zero_pct", int'(acc_pct), 0);
    chk("zero_cal", int'(acc_cal), 1);

    do_clear();
    run(85, 50, 2, N);
    wait_done();
    chk("gap85_pct", int'(acc_pct), 85);
    chk("gap85_samples", int'(sample_cnt), 100);

    do_clear();
    run(20, 0, 2, 39);
    clear = 1'b1; in_valid = 1'b1; in_score = 32'h0100_0000; in_label = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0; in_valid = 1'b0;
    chk("clear_samples", int'(sample_cnt), 0);
    chk("clear_correct", int'(correct_cnt), 0);
    nc = int'($urandom_range(100));
    run(nc, 20, 2, N);
    wait_done();
    chk("after_clear_pct", int'(acc_pct), nc);

    do_clear();
    run(50, 0, 2, N);
    repeat (5) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("mid_rst_cal", int'(acc_cal), 0);
    chk("mid_rst_pct", int'(acc_pct), 0);
    chk("mid_rst_samples", int'(sample_cnt), 0);
    chk("mid_rst_ready", int'(in_ready), 1);
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("post_rst_ready", int'(in_ready), 1);
    run(30, 10, 2, N);
    wait_done();
    chk("post_rst_pct", int'(acc_pct), 30);

    // Three-row instance: threshold row and zero row correct, -1 with label 1 wrong.
    v3 = 1'b1; s3 = 32'(TH); l3 = 1'b1;
    @(posedge clk); #1;
    v3 = 1'b0;
    chk("n3_thresh_correct", int'(cc3), 1);
    v3 = 1'b1; s3 = 32'h0000_0000; l3 = 1'b0;
    @(posedge clk); #1;
    s3 = 32'hFFFF_FFFF; l3 = 1'b1;
    @(posedge clk); #1;
    v3 = 1'b0;
    chk("n3_ready_low", int'(r3), 0);
    repeat (15) @(posedge clk);
    #1;
    chk("n3_samples", int'(sc3), 3);
    chk("n3_correct", int'(cc3), 2);
    chk("n3_pct", int'(pct3), 66);
    chk("n3_cal", int'(cal3), 1);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule

// File: doc/acc_calc.md
Name: acc_calc

Overview:
- Downstream stage of the predict network; it consumes one classifier score per test row together with that row's ground-truth label.
- It thresholds each score into a class and counts correct predictions over NUM_SAMPLES rows.
- After the last row it computes integer percent accuracy with a sequential divider and raises acc_cal, which the top level uses to end the run.
- All arithmetic is fixed-point; there is no real type in RTL.

Parameters:
- NUM_SAMPLES, 100, test rows per run (>=1).
- SCORE_W, 32, width of signed two's-complement score (Q8.24 by convention).
- THRESH, 32'sh0080_0000, decision threshold (0.5 in Q8.24); score >= THRESH means class 1.
- CNT_W, $clog2(NUM_SAMPLES+1), counter width (derived, not overridden).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- clear  in  1  synchronous restart; clears counters and returns to ACCUM.
- in_valid  in  1  score/label valid.
- in_ready  out  1  block accepts a sample this cycle.
- in_score  in  SCORE_W  signed predicted score.
- in_label  in  1  actual class (0/1).
- sample_cnt  out  CNT_W  samples accepted so far.
- correct_cnt  out  CNT_W  correct predictions so far.
- acc_pct  out  8  floor(correct_cnt*100/NUM_SAMPLES), range 0..100.
- acc_cal  out  1  accuracy valid; level, held high in DONE.

Behaviour:
- Reset (async assert, sync deassert internally) sets state=ACCUM and sample_cnt, correct_cnt, acc_pct, acc_cal, divider regs all 0. in_ready is 1 in ACCUM.
- States: ACCUM, DIVIDE, DONE.
- in_ready = (state==ACCUM); it is combinational from state only.
- ACCUM:
  - A transfer occurs when in_valid && in_ready.
  - On a transfer: pred = ($signed(in_score) >= THRESH); correct_cnt += (pred == in_label); sample_cnt += 1.
  - When the transfer is sample NUM_SAMPLES (sample_cnt == NUM_SAMPLES-1 before the increment), go to DIVIDE next cycle and load dividend = updated correct_cnt * 100 (width CNT_W+7), divisor = NUM_SAMPLES.
  - Cycles without in_valid leave all state unchanged, so gaps are allowed.
- DIVIDE:
  - Restoring shift-subtract, one quotient bit per cycle, MSB first, exactly DW = CNT_W+7 cycles (14 for the defaults).
  - On the last iteration, acc_pct is loaded with the truncated quotient (low 8 bits; the quotient is always <=100) and the state becomes DONE.
  - in_valid is ignored (in_ready = 0).
- DONE:
  - acc_cal = 1; acc_pct, sample_cnt and correct_cnt are held.
  - The state stays in DONE until clear or reset.
- Latency: acc_cal rises DW+1 rising edges after the edge that accepted the final sample.
- clear: in any state, on the next edge it zeroes counters, acc_pct, acc_cal and divider regs and enters ACCUM. clear has priority over a simultaneous transfer; that sample is dropped and not counted.
- Reset mid-DIVIDE or mid-ACCUM aborts immediately; outputs return to reset values.
- Counters never wrap: sample_cnt is bounded by NUM_SAMPLES because in_ready drops after the final sample.
- Score at exactly THRESH is class 1. Negative scores are compared signed.
- NUM_SAMPLES=1: the first transfer goes straight to DIVIDE.

Decomposition:
- Package acc_calc_pkg holds:
  - the state enum {ACCUM, DIVIDE, DONE} (2 bits);
  - constant PCT_SCALE = 100;
  - function for dividend width.
- Sub-module seq_divider (parameterised DW):
  - ports clk, rst_n, start, dividend, divisor, busy, done (1-cycle pulse), quotient;
  - acc_calc instantiates one and drives start on entry to DIVIDE.
- Top-level acc_calc contains the FSM, threshold comparator and counters.

Test Plan:
- Defaults, 100 samples, every score 0x0100_0000 with label 1 -> correct_cnt=100, acc_pct=100, acc_cal high exactly 15 edges after the last accept, in_ready=0 thereafter.
- 100 samples, scores alternating 0x0100_0000/0xFF00_0000 (negative), labels chosen so 67 match -> correct_cnt=67, acc_pct=67. Repeat with 0 matches -> acc_pct=0, acc_cal=1.
- NUM_SAMPLES=3, two correct -> acc_pct=66 (floor 200/3). Boundary row with score == THRESH and label 1 counts as correct.
- Random in_valid gaps (50% duty) over 100 samples with 85 correct -> acc_pct=85 and sample_cnt=100; no sample is counted twice; in_valid asserted in DIVIDE/DONE changes nothing.
- clear asserted with in_valid at sample 40 -> counters 0 next cycle, that sample not counted. A full run afterwards gives the correct result.
- rst_n dropped for 1 cycle during DIVIDE (cycle 5 of 14) -> all outputs 0 asynchronously, in_ready=1 after release, and a new run completes normally.
